// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller.
package cache_pkg;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 25;
  localparam int BLOCK_W  = 128;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  function automatic logic [31:0] get_word(input logic [BLOCK_W-1:0] blk, input logic [OFFSET_W-1:0] off);
    return blk[{off, 5'b00000} +: 32];
  endfunction
endpackage

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache; hits are stall-free,
// misses write back a dirty victim, fetch the block, then fill the line.
module data_cache_controller
  import cache_pkg::*;
#(
  parameter int NUM_LINES       = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int TAG_W           = 25
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          READ,
  input  logic                          WRITE,
  input  logic [31:0]                   ADDRESS,
  input  logic [31:0]                   WRITEDATA,
  output logic [31:0]                   READDATA,
  output logic                          BUSYWAIT,
  output logic                          MEM_READ,
  output logic                          MEM_WRITE,
  output logic [27:0]                   MEM_ADDRESS,
  output logic [WORDS_PER_BLOCK*32-1:0] MEM_WRITEDATA,
  input  logic [WORDS_PER_BLOCK*32-1:0] MEM_READDATA,
  input  logic                          MEM_BUSYWAIT
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int BLK_W = WORDS_PER_BLOCK * 32;

  logic [TAG_W-1:0]    tags  [NUM_LINES];
  logic [BLK_W-1:0]    data  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [BLK_W-1:0]    fill;
  state_t              state;

  logic [OFFSET_W-1:0] offset;
  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                req;
  logic                unused_addr_bits;

  assign offset           = ADDRESS[3:2];
  assign index            = ADDRESS[4 +: IDX_W];
  assign tag              = ADDRESS[31 -: TAG_W];
  assign hit              = valid[index] && (tags[index] == tag);
  assign req              = READ || WRITE;
  assign unused_addr_bits = &{1'b0, ADDRESS[1:0]};

  // Controller state and line storage; the store happens in IDLE once the line hits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (WRITE && hit) begin
            data[index][{offset, 5'b00000} +: 32] <= WRITEDATA;
            dirty[index] <= 1'b1;
          end else if (req && !hit) begin
            state <= (valid[index] && dirty[index]) ? WRITEBACK : FETCH;
          end else begin
            state <= IDLE;
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) state <= FETCH;
          else               state <= WRITEBACK;
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            fill  <= MEM_READDATA;
            state <= UPDATE;
          end else begin
            state <= FETCH;
          end
        end
        UPDATE: begin
          data[index]  <= fill;
          tags[index]  <= tag;
          valid[index] <= 1'b1;
          dirty[index] <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall, load data and memory-port outputs decoded from the current state.
  always_comb begin
    BUSYWAIT      = 1'b0;
    READDATA      = 32'h0000_0000;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 28'h000_0000;
    MEM_WRITEDATA = '0;
    if (RESET) begin
      BUSYWAIT = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          BUSYWAIT = req && !hit;
          if (READ && !WRITE && hit) READDATA = get_word(data[index], offset);
          else                       READDATA = 32'h0000_0000;
        end
        WRITEBACK: begin
          BUSYWAIT      = 1'b1;
          MEM_WRITE     = 1'b1;
          MEM_ADDRESS   = {tags[index], index};
          MEM_WRITEDATA = data[index];
        end
        FETCH: begin
          BUSYWAIT    = 1'b1;
          MEM_READ    = 1'b1;
          MEM_ADDRESS = ADDRESS[31:4];
        end
        UPDATE: BUSYWAIT = 1'b1;
        default: BUSYWAIT = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench: fixed-latency block memory model plus a scoreboard of expected load data.
module tb_data_cache_controller;
  localparam int LAT = 3;

  logic         CLK = 1'b0;
  logic         RESET, READ, WRITE, MEM_READ, MEM_WRITE, BUSYWAIT, MEM_BUSYWAIT;
  logic [31:0]  ADDRESS, WRITEDATA, READDATA;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;

  data_cache_controller dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  ref_arr [256];
  logic [127:0] mem_arr [64];
  int           cnt;
  logic         seen_rd, seen_wr;
  logic [27:0]  rd_addr, wb_addr;
  logic [127:0] wb_data;

  function automatic logic [31:0] blk_word(input int blk, input int w);
    logic [5:0] b;
    logic [1:0] wi;
    b  = blk[5:0];
    wi = w[1:0];
    return {4'hA, 18'h00000, b, wi, 2'b00};
  endfunction

  // Memory model: each request completes on its LAT-th cycle; abandoned requests restart.
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt != LAT - 1);
  assign MEM_READDATA = mem_arr[MEM_ADDRESS[5:0]];
  always @(posedge CLK) begin
    if (RESET || !(MEM_READ || MEM_WRITE)) cnt <= 0;
    else if (cnt == LAT - 1) begin
      cnt <= 0;
      if (MEM_WRITE) mem_arr[MEM_ADDRESS[5:0]] <= MEM_WRITEDATA;
    end else cnt <= cnt + 1;
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stall);
    logic [31:0] exp;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    if (wr) ref_arr[addr[9:2]] = wdata;
    else if (rd) exp_q.push_back(ref_arr[addr[9:2]]);
    seen_rd = 1'b0; seen_wr = 1'b0; stall = 0;
    #1;
    while (BUSYWAIT && stall < 50) begin
      if (MEM_WRITE && !seen_wr) begin seen_wr = 1'b1; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA; end
      if (MEM_READ && !seen_rd) begin seen_rd = 1'b1; rd_addr = MEM_ADDRESS; end
      stall++;
      @(negedge CLK); #1;
    end
    if (BUSYWAIT) begin
      checks++; errors++;
      $display("FAIL stall_timeout addr=%h busywait still high after %0d cycles", addr, stall);
    end
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      checks++;
      if (READDATA !== exp) begin
        errors++;
        $display("FAIL readdata addr=%h got=%h expected=%h", addr, READDATA, exp);
      end
    end
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 32'h0000_0010; WRITEDATA = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000 || READDATA !== 32'h0 ||
        MEM_ADDRESS !== 28'h0 || MEM_WRITEDATA !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs got bw=%b mr=%b mw=%b rd=%h ma=%h expected all zero",
               BUSYWAIT, MEM_READ, MEM_WRITE, READDATA, MEM_ADDRESS);
    end
    @(negedge CLK);
    RESET = 1'b0; READ = 1'b0;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0 || READDATA !== 32'h0) begin
      errors++;
      $display("FAIL idle_outputs got bw=%b rd=%h expected bw=0 rd=0", BUSYWAIT, READDATA);
    end
    @(negedge CLK);
  endtask

  task automatic test_clean_miss();
    int s;
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, s);
    checks++;
    if (s != 5 || !seen_rd || seen_wr || rd_addr !== 28'h000_0001) begin
      errors++;
      $display("FAIL clean_miss stall=%0d rd=%b wr=%b addr=%h expected stall=5 rd=1 wr=0 addr=0000001",
               s, seen_rd, seen_wr, rd_addr);
    end
  endtask

  task automatic test_read_hit();
    int s;
    access(1'b1, 1'b0, 32'h0000_0014, 32'h0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL read_hit_stall got=%0d expected=0", s); end
  endtask

  task automatic test_write_hit();
    int s;
    access(1'b0, 1'b1, 32'h0000_0018, 32'hDEAD_BEEF, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL write_hit_stall got=%0d expected=0", s); end
    access(1'b1, 1'b0, 32'h0000_0018, 32'h0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL write_readback_stall got=%0d expected=0", s); end
  endtask

  task automatic test_dirty_miss();
    int s;
    access(1'b1, 1'b0, 32'h0000_0098, 32'h0, s);
    checks++;
    if (s != 2 * LAT + 2) begin errors++; $display("FAIL dirty_miss_stall got=%0d expected=%0d", s, 2 * LAT + 2); end
    checks++;
    if (!seen_wr || wb_addr !== 28'h000_0001 || wb_data[95:64] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL writeback seen=%b addr=%h word2=%h expected seen=1 addr=0000001 word2=deadbeef",
               seen_wr, wb_addr, wb_data[95:64]);
    end
    checks++;
    if (!seen_rd || rd_addr !== 28'h000_0009) begin
      errors++;
      $display("FAIL refetch_addr seen=%b addr=%h expected seen=1 addr=0000009", seen_rd, rd_addr);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, s);
    checks++;
    if (s != LAT + 2 || seen_wr) begin
      errors++;
      $display("FAIL thrash_stall got=%0d wb=%b expected=%0d wb=0", s, seen_wr, LAT + 2);
    end
    access(1'b1, 1'b0, 32'h0000_0018, 32'h0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL thrash_hit_stall got=%0d expected=0", s); end
  endtask

  task automatic test_write_wins();
    int s;
    access(1'b1, 1'b1, 32'h0000_0120, 32'h1234_5678, s);
    checks++;
    if (s != LAT + 2) begin errors++; $display("FAIL rw_miss_stall got=%0d expected=%0d", s, LAT + 2); end
    access(1'b1, 1'b0, 32'h0000_0120, 32'h0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL rw_readback_stall got=%0d expected=0", s); end
  endtask

  task automatic test_drop();
    int s;
    READ = 1'b1; ADDRESS = 32'h0000_0300;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL drop_busy got=%b expected=1", BUSYWAIT); end
    READ = 1'b0;
    repeat (8) @(negedge CLK);
    access(1'b1, 1'b0, 32'h0000_0300, 32'h0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL drop_fill_hit stall=%0d expected=0", s); end
  endtask

  task automatic test_reset_mid_fetch();
    int s;
    READ = 1'b1; ADDRESS = 32'h0000_0200;
    @(negedge CLK); #1;
    checks++;
    if (MEM_READ !== 1'b1) begin errors++; $display("FAIL fetch_started mem_read=%b expected=1", MEM_READ); end
    RESET = 1'b1;
    @(negedge CLK); #1;
    checks++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort mem_read=%b busywait=%b expected 0 0", MEM_READ, BUSYWAIT);
    end
    RESET = 1'b0; READ = 1'b0;
    @(negedge CLK); #1;
    checks++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle mem_read=%b busywait=%b expected 0 0", MEM_READ, BUSYWAIT);
    end
    @(negedge CLK);
    access(1'b1, 1'b0, 32'h0000_0200, 32'h0, s);
    checks++;
    if (s != LAT + 2) begin errors++; $display("FAIL reread_miss stall=%0d expected=%0d", s, LAT + 2); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      mem_arr[i] = {blk_word(i, 3), blk_word(i, 2), blk_word(i, 1), blk_word(i, 0)};
    for (int i = 0; i < 256; i++) ref_arr[i] = blk_word(i / 4, i % 4);
    @(negedge CLK);
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_back_to_back();
    test_write_wins();
    test_drop();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
